// File: rtl/shift_reg_ctrl.sv
// Command sequencer owning a WIDTH-bit shift register: LOAD/SHL/SHR/ROR, one step per clock.
// Optional macro SHIFT_CTRL_COMPARE_EN adds a registered unsigned compare of the final value.
module shift_reg_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [AMT_W-1:0] cmd_amt_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SHIFT_CTRL_COMPARE_EN
    ,
    input  logic [WIDTH-1:0] cmp_ref_i,
    output logic             gr_o,
    output logic             eq_o,
    output logic             le_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    logic [1:0]       r_state;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_q;
    logic             r_ser;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    logic [1:0]       w_state_nxt;
    logic [AMT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_op_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_ser_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_ready_nxt;
    logic             w_enter_done;

    // State and datapath registers; status outputs are registered decodes of the next state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_q     <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_data  <= w_data_nxt;
            r_q     <= w_q_nxt;
            r_ser   <= w_ser_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state, step datapath and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_q_nxt     = r_q;
        w_ser_nxt   = r_ser;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && r_ready) begin
                    w_op_nxt   = cmd_op_i;
                    w_data_nxt = cmd_data_i;
                    if (cmd_op_i == OP_LOAD) begin
                        w_cnt_nxt   = AMT_W'(1);
                        w_state_nxt = S_EXEC;
                    end else if (cmd_amt_i == '0) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = cmd_amt_i;
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                case (r_op)
                    OP_LOAD: begin
                        w_q_nxt = r_data;
                    end
                    OP_SHL: begin
                        w_q_nxt   = {r_q[WIDTH-2:0], ser_i};
                        w_ser_nxt = r_q[WIDTH-1];
                    end
                    OP_SHR: begin
                        w_q_nxt   = {ser_i, r_q[WIDTH-1:1]};
                        w_ser_nxt = r_q[0];
                    end
                    default: begin
                        w_q_nxt   = {r_q[0], r_q[WIDTH-1:1]};
                        w_ser_nxt = r_q[0];
                    end
                endcase
                w_cnt_nxt = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_DONE);
        w_ready_nxt  = (w_state_nxt == S_IDLE);
        w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    end

    assign q_o         = r_q;
    assign ser_o       = r_ser;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign cmd_ready_o = r_ready;

`ifdef SHIFT_CTRL_COMPARE_EN
    logic r_gr;
    logic r_eq;
    logic r_le;

    // Compare the value the register holds once DONE is entered; held until the next DONE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_gr <= 1'b0;
            r_eq <= 1'b0;
            r_le <= 1'b0;
        end else if (w_enter_done) begin
            r_gr <= (w_q_nxt > cmp_ref_i);
            r_eq <= (w_q_nxt == cmp_ref_i);
            r_le <= (w_q_nxt < cmp_ref_i);
        end
    end

    assign gr_o = r_gr;
    assign eq_o = r_eq;
    assign le_o = r_le;
`else
    logic w_unused;
    assign w_unused = w_enter_done;
`endif

endmodule
